// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of ram_port_arbiter: request handshake plus per-requester read responses.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 64,
  parameter int BYTES      = 8
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][BYTES-1:0]      req_strobe;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_strobe, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_strobe, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Grants up to two of NUM_REQ requesters per cycle onto the two RAM ports and routes read data back.
// Optional macro RAM_ARB_ROUND_ROBIN_EN: round-robin priority; when undefined, fixed priority from requester 0.
module ram_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 64,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  localparam int BYTES       = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_port_arbiter_if.slave     bus,
  output logic                  en_1,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic [BYTES-1:0]      strobe_1,
  output logic [DATA_WIDTH-1:0] wdata_1,
  input  logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  en_2,
  output logic [ADDR_WIDTH-1:0] addr_2,
  output logic [BYTES-1:0]      strobe_2,
  output logic [DATA_WIDTH-1:0] wdata_2,
  input  logic [DATA_WIDTH-1:0] rdata_2
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW1  = ID_W + 1;

  typedef logic [ID_W-1:0] id_t;
  typedef struct packed {
    logic vld;
    id_t  id;
  } rd_tag_t;

  id_t  ptr;
  id_t  idx_a;
  id_t  idx_b;
  logic gnt_a;
  logic gnt_b;

  // Scan from ptr; the first valid requester takes port 1, the next non-conflicting one port 2.
  always_comb begin
    logic [PW1-1:0] pos;
    id_t            idx;
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    idx_a = '0;
    idx_b = '0;
    pos   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + PW1'(k);
      if (pos >= PW1'(NUM_REQ)) pos = pos - PW1'(NUM_REQ);
      idx = pos[ID_W-1:0];
      if (!reset && bus.req_valid[idx]) begin
        if (!gnt_a) begin
          gnt_a = 1'b1;
          idx_a = idx;
        end else if (!gnt_b &&
                     !(bus.req_addr[idx] == bus.req_addr[idx_a] &&
                       (|bus.req_strobe[idx_a] || |bus.req_strobe[idx]))) begin
          gnt_b = 1'b1;
          idx_b = idx;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_a) bus.req_ready[idx_a] = 1'b1;
    if (gnt_b) bus.req_ready[idx_b] = 1'b1;
  end

  // Idle ports drive all-zero outputs to the RAM.
  assign en_1     = gnt_a;
  assign addr_1   = gnt_a ? bus.req_addr[idx_a]   : '0;
  assign strobe_1 = gnt_a ? bus.req_strobe[idx_a] : '0;
  assign wdata_1  = gnt_a ? bus.req_wdata[idx_a]  : '0;
  assign en_2     = gnt_b;
  assign addr_2   = gnt_b ? bus.req_addr[idx_b]   : '0;
  assign strobe_2 = gnt_b ? bus.req_strobe[idx_b] : '0;
  assign wdata_2  = gnt_b ? bus.req_wdata[idx_b]  : '0;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic [PW1-1:0] ptr_inc;

  assign ptr_inc = {1'b0, (gnt_b ? idx_b : idx_a)} + PW1'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_a) begin
      ptr <= (ptr_inc == PW1'(NUM_REQ)) ? '0 : ptr_inc[ID_W-1:0];
    end
  end
`else
  assign ptr = '0;
`endif

  rd_tag_t [READ_LATENCY-1:0] pipe_1;
  rd_tag_t [READ_LATENCY-1:0] pipe_2;
  rd_tag_t                    tag_1;
  rd_tag_t                    tag_2;
  rd_tag_t                    tail_1;
  rd_tag_t                    tail_2;

  assign tag_1  = '{vld: gnt_a && (strobe_1 == '0), id: idx_a};
  assign tag_2  = '{vld: gnt_b && (strobe_2 == '0), id: idx_b};
  assign tail_1 = pipe_1[READ_LATENCY-1];
  assign tail_2 = pipe_2[READ_LATENCY-1];

  // NOTE: only the small tag pipelines are reset; read data is never stored here, it flows from the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_1 <= '0;
      pipe_2 <= '0;
    end else begin
      pipe_1[0] <= tag_1;
      pipe_2[0] <= tag_2;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_1[i] <= pipe_1[i-1];
        pipe_2[i] <= pipe_2[i-1];
      end
    end
  end

  // The two ports never return to the same requester in one cycle, so the writes below never collide.
  always_comb begin
    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    if (!reset && tail_1.vld) begin
      bus.resp_valid[tail_1.id] = 1'b1;
      bus.resp_rdata[tail_1.id] = rdata_1;
    end
    if (!reset && tail_2.vld) begin
      bus.resp_valid[tail_2.id] = 1'b1;
      bus.resp_rdata[tail_2.id] = rdata_2;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized plus directed bench for ram_port_arbiter: grant reference model and read-response scoreboard.
module tb_ram_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int AW      = 17;
  localparam int DW      = 64;
  localparam int BW      = 8;
  localparam int L       = 2;
  localparam int BYTES   = DW / BW;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTES(BYTES)) bus ();

  logic             en_1, en_2;
  logic [AW-1:0]    addr_1, addr_2;
  logic [BYTES-1:0] strobe_1, strobe_2;
  logic [DW-1:0]    wdata_1, wdata_2, rdata_1, rdata_2;

  ram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .en_1(en_1), .addr_1(addr_1), .strobe_1(strobe_1), .wdata_1(wdata_1), .rdata_1(rdata_1),
    .en_2(en_2), .addr_2(addr_2), .strobe_2(strobe_2), .wdata_2(wdata_2), .rdata_2(rdata_2)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BYTES-1:0] s);
    merge = old;
    for (int b = 0; b < BYTES; b++) if (s[b]) merge[b*BW +: BW] = wd[b*BW +: BW];
  endfunction

  // Dual-port RAM with L-cycle read latency; addresses used by the bench stay below 64.
  logic [DW-1:0] ram_mem [64] = '{default: '0};
  logic [DW-1:0] rpipe_1 [L]  = '{default: '0};
  logic [DW-1:0] rpipe_2 [L]  = '{default: '0};

  always @(posedge clk) begin
    if (en_1 && strobe_1 != '0) ram_mem[addr_1[5:0]] <= merge(ram_mem[addr_1[5:0]], wdata_1, strobe_1);
    if (en_2 && strobe_2 != '0) ram_mem[addr_2[5:0]] <= merge(ram_mem[addr_2[5:0]], wdata_2, strobe_2);
    if (en_1) rpipe_1[0] <= ram_mem[addr_1[5:0]];
    if (en_2) rpipe_2[0] <= ram_mem[addr_2[5:0]];
    for (int i = 1; i < L; i++) begin
      rpipe_1[i] <= rpipe_1[i-1];
      rpipe_2[i] <= rpipe_2[i-1];
    end
  end
  assign rdata_1 = rpipe_1[L-1];
  assign rdata_2 = rpipe_2[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: shadow memory, priority pointer and expected read responses.
  typedef struct { bit a_ok; int a; bit b_ok; int b; } grant_t;
  typedef struct { int id; int due; logic [DW-1:0] data; } exp_t;

  logic [DW-1:0]      model_mem [64] = '{default: '0};
  int                 model_ptr = 0;
  exp_t               exp_q [$];
  logic [NUM_REQ-1:0] acc_mask = '0;

  function automatic grant_t ref_grant(input logic [NUM_REQ-1:0] v,
                                       input logic [NUM_REQ-1:0][AW-1:0] a,
                                       input logic [NUM_REQ-1:0][BYTES-1:0] s, input int p);
    grant_t g;
    int     order [$];
    int     c;
    g.a_ok = 0; g.a = 0; g.b_ok = 0; g.b = 0;
    for (int k = 0; k < NUM_REQ; k++) if (v[(p + k) % NUM_REQ]) order.push_back((p + k) % NUM_REQ);
    if (order.size() == 0) return g;
    g.a_ok = 1;
    g.a    = order.pop_front();
    foreach (order[j]) begin
      c = order[j];
      if (!g.b_ok && !(a[c] == a[g.a] && (s[g.a] != '0 || s[c] != '0))) begin
        g.b_ok = 1;
        g.b    = c;
      end
    end
    return g;
  endfunction

  task automatic model_accept(input int r);
    exp_t e;
    if (bus.req_strobe[r] == '0) begin
      e.id   = r;
      e.due  = cyc + L;
      e.data = model_mem[bus.req_addr[r][5:0]];
      exp_q.push_back(e);
    end else begin
      model_mem[bus.req_addr[r][5:0]] = merge(model_mem[bus.req_addr[r][5:0]], bus.req_wdata[r],
                                              bus.req_strobe[r]);
    end
  endtask

  always @(negedge clk) begin
    grant_t             g;
    logic [NUM_REQ-1:0] exp_ready;
    if (reset) begin
      check("reset_req_ready", 64'(bus.req_ready), 64'(0));
      check("reset_en", 64'({en_1, en_2}), 64'(0));
      model_ptr = 0;
      exp_q.delete();
      acc_mask = '0;
    end else begin
      g = ref_grant(bus.req_valid, bus.req_addr, bus.req_strobe, model_ptr);
      exp_ready = '0;
      if (g.a_ok) exp_ready[g.a] = 1'b1;
      if (g.b_ok) exp_ready[g.b] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("en_1", 64'(en_1), 64'(g.a_ok));
      check("addr_1", 64'(addr_1), g.a_ok ? 64'(bus.req_addr[g.a]) : 64'(0));
      check("strobe_1", 64'(strobe_1), g.a_ok ? 64'(bus.req_strobe[g.a]) : 64'(0));
      check("wdata_1", wdata_1, g.a_ok ? bus.req_wdata[g.a] : 64'(0));
      check("en_2", 64'(en_2), 64'(g.b_ok));
      check("addr_2", 64'(addr_2), g.b_ok ? 64'(bus.req_addr[g.b]) : 64'(0));
      check("strobe_2", 64'(strobe_2), g.b_ok ? 64'(bus.req_strobe[g.b]) : 64'(0));
      check("wdata_2", wdata_2, g.b_ok ? bus.req_wdata[g.b] : 64'(0));
      if (g.a_ok) model_accept(g.a);
      if (g.b_ok) model_accept(g.b);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (g.a_ok) model_ptr = ((g.b_ok ? g.b : g.a) + 1) % NUM_REQ;
`endif
      acc_mask = bus.req_ready & bus.req_valid;
    end
  end

  // Monitor: pops every response due this cycle and flags any response nobody expected.
  always @(negedge clk) begin
    exp_t               e;
    logic [NUM_REQ-1:0] seen;
    if (reset) begin
      check("reset_resp_valid", 64'(bus.resp_valid), 64'(0));
    end else begin
      seen = '0;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check($sformatf("resp_valid[%0d]", e.id), 64'(bus.resp_valid[e.id]), 64'(1));
        check($sformatf("resp_rdata[%0d]", e.id), bus.resp_rdata[e.id], e.data);
        seen[e.id] = 1'b1;
      end
      check("unexpected_resp_valid", 64'(bus.resp_valid & ~seen), 64'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc_mask;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a, input logic [BYTES-1:0] s,
                         input logic [DW-1:0] d);
    bus.req_valid[r]  = 1'b1;
    bus.req_addr[r]   = a;
    bus.req_strobe[r] = s;
    bus.req_wdata[r]  = d;
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int n = 0; n < max && bus.req_valid != '0; n++) step();
    check({name, "_drain_timeout"}, 64'(bus.req_valid), 64'(0));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '1;
    bus.req_addr   = '0;
    bus.req_strobe = '0;
    bus.req_wdata  = '0;
    for (int r = 0; r < NUM_REQ; r++) bus.req_addr[r] = AW'(r);
    repeat (3) step();
    bus.req_valid = '0;
    reset         = 1'b0;
    step();

    // Write then read-back on another requester.
    set_req(0, AW'('h10), 8'hFF, 64'h1122_3344_5566_7788);
    step();
    set_req(1, AW'('h10), 8'h00, 64'h0);
    wait_idle("write_read", 10);
    repeat (L + 1) step();

    // Two writes to one address: serialised, read-back sees the later one.
    set_req(0, AW'('h20), 8'hFF, 64'hAAAA_0000_0000_0001);
    set_req(1, AW'('h20), 8'hFF, 64'hBBBB_0000_0000_0002);
    @(negedge clk);
    check("same_addr_writes_ready", 64'(bus.req_ready), 64'(4'b0001));
    wait_idle("same_addr_writes", 10);
    set_req(2, AW'('h20), 8'h00, 64'h0);
    wait_idle("same_addr_read", 10);
    repeat (L + 1) step();

    // Two reads on different addresses right after reset: both granted together.
    pulse_reset();
    set_req(0, AW'('h10), 8'h00, 64'h0);
    set_req(2, AW'('h20), 8'h00, 64'h0);
    @(negedge clk);
    check("dual_read_ready", 64'(bus.req_ready), 64'(4'b0101));
    step();
    repeat (L + 1) step();

    // All requesters reading continuously for four cycles.
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < NUM_REQ; r++) if (!bus.req_valid[r]) set_req(r, AW'('h30 + r), 8'h00, 64'h0);
      @(negedge clk);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      check($sformatf("all_read_c%0d", c), 64'(bus.req_ready), (c % 2 == 0) ? 64'(4'b0011) : 64'(4'b1100));
`else
      check($sformatf("all_read_c%0d", c), 64'(bus.req_ready), 64'(4'b0011));
`endif
      step();
    end
    wait_idle("all_read", 20);
    repeat (L + 1) step();

    // Reset one cycle after a read is accepted drops that read; the next read returns normally.
    set_req(0, AW'('h10), 8'h00, 64'h0);
    step();
    pulse_reset();
    set_req(1, AW'('h10), 8'h00, 64'h0);
    wait_idle("post_reset_read", 10);
    repeat (L + 2) step();

    // Randomized traffic over a small address range to provoke conflicts.
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (!bus.req_valid[r] && $urandom_range(0, 99) < 60)
          set_req(r, AW'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 0) ? BYTES'(0) : BYTES'($urandom_range(1, 255)),
                  {$urandom, $urandom});
      step();
    end
    wait_idle("random", 100);
    repeat (L + 2) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
